detector_jogada: RTL

- Input-conditioning stage directly upstream of the memory-game datapath.
- Takes the raw, asynchronous push-button vector from the board and synchronises and debounces it.
- Validates it as a single-button press, then delivers one registered play code plus a single-cycle `tem_jogada` pulse per physical press.
- Multi-button presses are flagged and discarded, so the game FSM only ever sees clean one-hot plays.

---
 rtl/jogo_pkg.sv | 23 ++
 rtl/debounce_botoes.sv | 61 ++++++
 rtl/detector_jogada.sv | 114 +++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// ---------------------------------------------------------------------------
// jogo_pkg
// Shared constants for the memory-game input stage: FSM state encodings of
// the play detector and the debounce lengths used for simulation and board
// builds.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package jogo_pkg;

  // Play detector state encodings (encoding 3 is unused)
  localparam logic [1:0] ESPERA      = 2'd0;
  localparam logic [1:0] PRESSIONADO = 2'd1;
  localparam logic [1:0] SOLTAR      = 2'd2;

  // Debounce lengths: short for simulation, long enough for real switches on the board
  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_PLACA = 20;

endpackage

`default_nettype wire

// File: rtl/debounce_botoes.sv
// ---------------------------------------------------------------------------
// debounce_botoes
// Two-flop synchroniser plus a shared stability counter for a vector of raw
// push buttons. A new vector value is accepted into `filtrado` only after it
// has stayed unchanged for DEBOUNCE_CICLOS consecutive synchronised cycles.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_botoes #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] filtrado
);

  localparam int                CONT_W = $clog2(DEBOUNCE_CICLOS + 1);
  // The load happens on the cycle the counter would step onto DEBOUNCE_CICLOS,
  // so the counter itself never holds a value above DEBOUNCE_CICLOS-1.
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sync_a;
  logic [N_BOTOES-1:0] sync_b;
  logic [N_BOTOES-1:0] sync_ant;
  logic [CONT_W-1:0]   cont;

  // Two-flop synchroniser, plus a copy of the previous synchronised value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      sync_ant <= '0;
    end else begin
      sync_a   <= botoes;
      sync_b   <= sync_a;
      sync_ant <= sync_b;
    end
  end

  // Stability counter: restart on any movement or when already filtered,
  // accept the value once it has been stable long enough
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont     <= '0;
      filtrado <= '0;
    end else if ((sync_b == filtrado) || (sync_b != sync_ant)) begin
      cont <= '0;
    end else if (cont >= LIMITE) begin
      filtrado <= sync_b;
      cont     <= '0;
    end else begin
      cont <= cont + CONT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/detector_jogada.sv
// ---------------------------------------------------------------------------
// detector_jogada
// Turns the raw button vector into clean one-hot plays for the game FSM:
// debounces the buttons, then emits one registered play code with a
// single-cycle `tem_jogada` pulse per physical press. Multi-button presses
// raise `jogada_invalida` and are discarded until every button is released.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PLACA
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_invalida,
  output logic [N_BOTOES-1:0] db_filtrado,
  output logic [1:0]          db_estado
);

  logic [N_BOTOES-1:0] filtrado;
  logic [N_BOTOES-1:0] filtrado_ant;
  logic [1:0]          estado;
  logic [1:0]          estado_prox;
  logic [N_BOTOES-1:0] jogada_prox;
  logic                tem_prox;
  logic                invalida_prox;
  logic                evento_press;
  logic                um_botao;

  debounce_botoes #(
    .N_BOTOES        (N_BOTOES),
    .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .botoes   (botoes),
    .filtrado (filtrado)
  );

  // A press is a 0-to-nonzero edge of the debounced vector; a button still
  // held after `limpa` therefore cannot retrigger a play.
  assign evento_press = (filtrado_ant == '0) && (filtrado != '0);
  assign um_botao     = $onehot(filtrado);

  // State register, delayed debounced vector and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= ESPERA;
      filtrado_ant    <= '0;
      jogada          <= '0;
      tem_jogada      <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      estado          <= estado_prox;
      filtrado_ant    <= filtrado;
      jogada          <= jogada_prox;
      tem_jogada      <= tem_prox;
      jogada_invalida <= invalida_prox;
    end
  end

  // Next-state logic; `limpa` overrides everything
  always_comb begin
    estado_prox = estado;
    if (limpa) begin
      estado_prox = ESPERA;
    end else begin
      case (estado)
        ESPERA: begin
          if (evento_press) begin
            estado_prox = um_botao ? PRESSIONADO : SOLTAR;
          end
        end
        PRESSIONADO, SOLTAR: begin
          if (filtrado == '0) begin
            estado_prox = ESPERA;
          end
        end
        default: estado_prox = ESPERA;
      endcase
    end
  end

  // Output decode: a press seen in ESPERA either loads a play or flags it
  always_comb begin
    jogada_prox   = jogada;
    tem_prox      = 1'b0;
    invalida_prox = 1'b0;
    if (limpa) begin
      jogada_prox = '0;
    end else if ((estado == ESPERA) && evento_press) begin
      if (um_botao) begin
        jogada_prox = filtrado;
        tem_prox    = 1'b1;
      end else begin
        invalida_prox = 1'b1;
      end
    end
  end

  assign db_filtrado = filtrado;
  assign db_estado   = estado;

endmodule

`default_nettype wire
